mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
// Shares the single-port 128x32 Memory between two requesters: port 0 = MIPS CPU,
// port 1 = auxiliary master (program loader / debug reader). Arbitrates, sequences
// one CS/WE access at a time, captures read data, returns a one-cycle ack.
// Sits between the masters and Memory; the top level wires Mem_Bus tristate from mem_drive.
// PARAMETERS
// ADDR_W    7   memory word-address width
// DATA_W    32  data width
// RR_MODE   0   0 = fixed priority (port 0 wins) with anti-starvation; 1 = round-robin
// MAX_WAIT  4   fixed mode only: consecutive lost arbitrations before port 1 is forced to win
// PORTS
// CLK        in   1       system clock; Memory registers on negedge CLK
// RST        in   1       synchronous, active-high reset
// req0/req1  in   1       access request; hold with we/addr/wdata stable until ack
// we0/we1    in   1       1 = write, 0 = read
// addr0/1    in   ADDR_W  word address
// wdata0/1   in   DATA_W  write data
// ack0/ack1  out  1       one-cycle pulse: transaction complete, rdata valid (reads)
// rdata0/1   out  DATA_W  read data, held until that port's next read ack
// mem_cs     out  1       Memory CS
// mem_we     out  1       Memory WE
// mem_addr   out  ADDR_W  Memory ADDR
// mem_wdata  out  DATA_W  value top level drives onto Mem_Bus when mem_drive=1
// mem_drive  out  1       Mem_Bus drive enable (= mem_we)
// mem_rdata  in   DATA_W  Mem_Bus as seen by the arbiter
// busy       out  1       high in ACCESS and RESP
// grant      out  1       port owning current/last transaction
// BEHAVIOUR
// - Reset (sync, RST high at posedge): state=IDLE; mem_cs=mem_we=mem_drive=0; mem_addr=0;
//   mem_wdata=0; ack0=ack1=0; rdata0=rdata1=0; busy=0; grant=1 (port 0 first in RR); wait_cnt=0.
// - FSM: IDLE -> ACCESS -> RESP -> IDLE. Exactly 3 cycles per transaction, req-to-ack latency 2.
// - IDLE: sample req0/req1; none -> stay. Winner latched into grant together with its
//   we/addr/wdata (later changes on inputs ignored until next IDLE).
// - ACCESS: mem_cs=1, mem_addr=latched addr; write: mem_we=mem_drive=1, mem_wdata=latched data
//   (Memory writes at mid-cycle negedge). Read: mem_we=0; Memory presents data after negedge;
//   at posedge ending ACCESS, mem_rdata captured into rdata[grant].
// - RESP: ack[grant]=1 for this cycle only; mem_cs=mem_we=mem_drive=0. Other ack stays 0.
// - req still high in next IDLE = new transaction (masters drop req on seeing ack).
// - Arbitration, RR_MODE=1: both requesting -> port != grant wins; single requester wins.
// - Arbitration, RR_MODE=0: port 0 wins ties unless wait_cnt==MAX_WAIT, then port 1 wins.
//   wait_cnt: +1 (saturating at MAX_WAIT) each IDLE decision where req1=1 loses; cleared when
//   port 1 is granted or req1=0 in IDLE.
// - Never two accesses overlapping; mem_cs high only in ACCESS; mem_drive never high on reads.
// - Reset mid-ACCESS: write at that negedge may already have occurred; ack suppressed, FSM to
//   IDLE, rdata not updated. Reset mid-RESP: ack cleared same edge.
// - Address used as-is (no wrap logic); 7-bit address covers all 128 words.
// TESTING
// 1 Write then read, port 0: req0,we0=1,addr0=7'h10,wdata0=32'hDEADBEEF -> mem_cs/mem_we high
//   1 cycle, ack0 2 cycles after req; read addr 7'h10 -> ack0, rdata0=32'hDEADBEEF.
// 2 Simultaneous req0/req1 reads, RR_MODE=1, after reset -> port 0 served first, port 1 next;
//   acks 3 cycles apart, never same cycle.
// 3 RR_MODE=0, MAX_WAIT=4, req0 held high continuously, req1 high -> port 0 granted 4 times,
//   5th grant goes to port 1, wait_cnt returns to 0.
// 4 Input change during ACCESS: alter addr0/wdata0 after grant -> memory receives latched
//   values only; readback confirms original data.
// 5 RST asserted in RESP of a port 1 read -> ack1=0 next cycle, all outputs at reset values,
//   new req0 served normally afterward.
// 6 Idle bus: no reqs for 20 cycles -> mem_cs, mem_drive, acks stay 0, busy=0.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the single-port 128x32 Memory between the CPU
// (port 0) and an auxiliary loader/debug master (port 1).
// Ports: CLK, RST (sync, active-high); per master req/we/addr/wdata in,
//   ack (1-cycle pulse) and rdata (held) out; mem_cs/mem_we/mem_addr/
//   mem_wdata/mem_drive toward Memory, mem_rdata from Mem_Bus;
//   busy (ACCESS or RESP), grant (owner of current/last transaction).
module mem_bus_arbiter #(
   parameter int ADDR_W   = 7,
   parameter int DATA_W   = 32,
   parameter int RR_MODE  = 0,
   parameter int MAX_WAIT = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              mem_cs,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_drive,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              grant
);

   localparam int WC_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
   localparam logic [WC_W-1:0] WC_MAX = WC_W'(MAX_WAIT);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t            state_q, state_d;
   logic              mem_cs_q, mem_cs_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              ack0_q, ack0_d;
   logic              ack1_q, ack1_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic              busy_q, busy_d;
   logic              grant_q, grant_d;
   logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic              win;

   always_comb begin
      // Winner of an IDLE decision: a lone requester always wins; a tie
      // alternates (RR) or goes to port 0 until port 1 has lost MAX_WAIT times.
      win = req1;
      if (req0 && req1) begin
         if (RR_MODE != 0) win = ~grant_q;
         else              win = (wait_cnt_q == WC_MAX);
      end
   end

   always_comb begin
      state_d     = state_q;
      mem_cs_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      ack0_d      = 1'b0;
      ack1_d      = 1'b0;
      rdata0_d    = rdata0_q;
      rdata1_d    = rdata1_q;
      grant_d     = grant_q;
      wait_cnt_d  = wait_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (!req1 || win)              wait_cnt_d = '0;
            else if (wait_cnt_q != WC_MAX) wait_cnt_d = wait_cnt_q + 1'b1;
            if (req0 || req1) begin
               // Latch the winner's request; inputs are ignored until next IDLE.
               state_d     = ACCESS;
               grant_d     = win;
               mem_cs_d    = 1'b1;
               mem_we_d    = win ? we1 : we0;
               mem_addr_d  = win ? addr1 : addr0;
               mem_wdata_d = win ? wdata1 : wdata0;
            end
         end
         ACCESS: begin
            // Memory drove read data at the mid-cycle negedge.
            state_d = RESP;
            if (!mem_we_q) begin
               if (grant_q) rdata1_d = mem_rdata;
               else         rdata0_d = mem_rdata;
            end
            ack0_d = ~grant_q;
            ack1_d = grant_q;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         mem_cs_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
         busy_q      <= 1'b0;
         grant_q     <= 1'b1;
         wait_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         mem_cs_q    <= mem_cs_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         ack0_q      <= ack0_d;
         ack1_q      <= ack1_d;
         rdata0_q    <= rdata0_d;
         rdata1_q    <= rdata1_d;
         busy_q      <= busy_d;
         grant_q     <= grant_d;
         wait_cnt_q  <= wait_cnt_d;
      end
   end

   assign mem_cs    = mem_cs_q;
   assign mem_we    = mem_we_q;
   assign mem_drive = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign ack0      = ack0_q;
   assign ack1      = ack1_q;
   assign rdata0    = rdata0_q;
   assign rdata1    = rdata1_q;
   assign busy      = busy_q;
   assign grant     = grant_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: two arbiter instances (index 0 fixed priority,
// index 1 round-robin), each with its own negedge-clocked 128x32 memory.
module tb_mem_bus_arbiter;

   localparam int AW = 7;
   localparam int DW = 32;

   logic                clk = 1'b0;
   logic                rst;
   logic                mem_init;
   logic [1:0]          req0, req1, we0, we1;
   logic [1:0][AW-1:0]  addr0, addr1, mem_addr;
   logic [1:0][DW-1:0]  wdata0, wdata1, rdata0, rdata1;
   logic [1:0][DW-1:0]  mem_wdata, mem_rdata;
   logic [1:0]          ack0, ack1, mem_cs, mem_we, mem_drive;
   logic [1:0]          busy, grant;
   logic [DW-1:0]       mem [2][128];

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      mem_bus_arbiter #(
         .ADDR_W(AW), .DATA_W(DW), .RR_MODE(g), .MAX_WAIT(4)
      ) u_dut (
         .CLK(clk), .RST(rst),
         .req0(req0[g]), .req1(req1[g]),
         .we0(we0[g]), .we1(we1[g]),
         .addr0(addr0[g]), .addr1(addr1[g]),
         .wdata0(wdata0[g]), .wdata1(wdata1[g]),
         .ack0(ack0[g]), .ack1(ack1[g]),
         .rdata0(rdata0[g]), .rdata1(rdata1[g]),
         .mem_cs(mem_cs[g]), .mem_we(mem_we[g]),
         .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
         .mem_drive(mem_drive[g]), .mem_rdata(mem_rdata[g]),
         .busy(busy[g]), .grant(grant[g])
      );
   end

   // Memory device: writes and read output both happen at the negedge.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (mem_init) begin
            for (int i = 0; i < 128; i++) mem[d][i] <= '0;
            mem_rdata[d] <= '0;
         end else begin
            if (mem_cs[d] && mem_drive[d]) mem[d][mem_addr[d]] <= mem_wdata[d];
            if (mem_cs[d] && !mem_we[d])   mem_rdata[d] <= mem[d][mem_addr[d]];
         end
      end
   end

   typedef struct {
      int          p;
      logic        w;
      logic [AW-1:0] a;
      logic [DW-1:0] wd;
      logic [DW-1:0] er;
   } vec_t;

   vec_t tbl[10];

   // random-phase reference state
   int            free_e[2], dec_e[2], dec_p[2], lose[2];
   logic          dec_w[2], lastg[2];
   logic [DW-1:0] mm[2][128];
   logic [DW-1:0] pend[2];
   logic [DW-1:0] erd[2][2];

   task automatic check(input string name, input logic [127:0] act,
                        input logic [127:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int d, input int p, input logic r, input logic w,
                        input logic [AW-1:0] a, input logic [DW-1:0] wd);
      if (p == 0) begin
         req0[d] = r; we0[d] = w; addr0[d] = a; wdata0[d] = wd;
      end else begin
         req1[d] = r; we1[d] = w; addr1[d] = a; wdata1[d] = wd;
      end
   endtask

   task automatic clr_inputs();
      req0 = '0; req1 = '0; we0 = '0; we1 = '0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic pulse_mem_init();
      mem_init = 1'b1;
      @(negedge clk);
      #1;
      mem_init = 1'b0;
   endtask

   task automatic check_reset(input int d, input string tag);
      check($sformatf("%s_ctl%0d", tag, d),
            {mem_cs[d], mem_we[d], mem_drive[d], ack0[d], ack1[d], busy[d]}, 0);
      check($sformatf("%s_grant%0d", tag, d), grant[d], 1);
      check($sformatf("%s_data%0d", tag, d),
            {rdata0[d], rdata1[d], mem_wdata[d], 25'(mem_addr[d])}, 0);
   endtask

   // One uncontended transaction; latency, strobe widths and ack routing checked.
   task automatic txn(input int d, input int p, input logic w,
                      input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      output logic [DW-1:0] rd);
      int lat, ncs, nwe, ndrv, nbad;
      lat = -1; ncs = 0; nwe = 0; ndrv = 0; nbad = 0;
      drive(d, p, 1'b1, w, a, wd);
      for (int k = 1; k <= 8 && lat < 0; k++) begin
         tick();
         if (mem_cs[d]) begin
            ncs++;
            if (mem_addr[d] !== a) nbad++;
         end
         if (mem_we[d])    nwe++;
         if (mem_drive[d]) ndrv++;
         if ((p == 0) ? ack1[d] : ack0[d]) nbad++;
         if ((p == 0) ? ack0[d] : ack1[d]) lat = k;
      end
      drive(d, p, 1'b0, w, a, wd);
      rd = (p == 0) ? rdata0[d] : rdata1[d];
      check($sformatf("txn_lat_d%0d_p%0d", d, p), lat, 2);
      check($sformatf("txn_cs_d%0d_p%0d", d, p), ncs, 1);
      check($sformatf("txn_we_d%0d_p%0d", d, p), {nwe, ndrv}, {32'(w), 32'(w)});
      check($sformatf("txn_bad_d%0d_p%0d", d, p), nbad, 0);
      check($sformatf("txn_grant_d%0d_p%0d", d, p), grant[d], p);
      tick();
      check($sformatf("txn_idle_d%0d_p%0d", d, p), {busy[d], ack0[d], ack1[d]}, 0);
   endtask

   task automatic new_req(input int d, input int p);
      logic [AW-1:0] a;
      a = ($urandom % 2 == 0) ? 7'($urandom_range(0, 7))
                              : 7'(120 + $urandom_range(0, 7));
      drive(d, p, 1'b1, 1'($urandom % 2), a, $urandom);
   endtask

   task automatic run_random(input int ncyc);
      logic wn, ww, ea0, ea1, ecs, ebusy, acked, cur;
      logic [AW-1:0] wa;
      for (int d = 0; d < 2; d++) begin
         free_e[d] = 0; dec_e[d] = -10; dec_p[d] = 0; lose[d] = 0;
         dec_w[d] = 1'b0; lastg[d] = 1'b1; pend[d] = '0;
         erd[d][0] = '0; erd[d][1] = '0;
         for (int i = 0; i < 128; i++) mm[d][i] = '0;
      end
      for (int e = 0; e < ncyc; e++) begin
         // decision at edge e for any DUT that is idle
         for (int d = 0; d < 2; d++) begin
            if (e >= free_e[d]) begin
               if (req0[d] || req1[d]) begin
                  if (req0[d] && req1[d])
                     wn = (d == 1) ? !lastg[d] : (lose[d] == 4);
                  else
                     wn = req1[d];
                  if (req1[d] && !wn) lose[d] = (lose[d] < 4) ? lose[d] + 1 : 4;
                  else                lose[d] = 0;
                  lastg[d] = wn;
                  dec_e[d] = e;
                  dec_p[d] = int'(wn);
                  free_e[d] = e + 3;
                  wa = wn ? addr1[d] : addr0[d];
                  ww = wn ? we1[d] : we0[d];
                  dec_w[d] = ww;
                  if (ww) mm[d][wa] = wn ? wdata1[d] : wdata0[d];
                  else    pend[d] = mm[d][wa];
               end else begin
                  lose[d] = 0;
               end
            end
         end
         tick();
         for (int d = 0; d < 2; d++) begin
            if (e == dec_e[d] + 1 && !dec_w[d]) erd[d][dec_p[d]] = pend[d];
            ea0   = (e == dec_e[d] + 1) && (dec_p[d] == 0);
            ea1   = (e == dec_e[d] + 1) && (dec_p[d] == 1);
            ecs   = (e == dec_e[d]);
            ebusy = ecs || (e == dec_e[d] + 1);
            check($sformatf("rnd_d%0d_c%0d", d, e),
                  {ack0[d], ack1[d], mem_cs[d], mem_drive[d], busy[d], grant[d],
                   rdata0[d], rdata1[d]},
                  {ea0, ea1, ecs, ecs && dec_w[d], ebusy, lastg[d],
                   erd[d][0], erd[d][1]});
            for (int p = 0; p < 2; p++) begin
               acked = (p == 0) ? ea0 : ea1;
               cur   = (p == 0) ? req0[d] : req1[d];
               if (acked) begin
                  if ($urandom_range(0, 3) == 0) new_req(d, p);
                  else if (p == 0) req0[d] = 1'b0;
                  else             req1[d] = 1'b0;
               end else if (!cur && $urandom_range(0, 2) == 0) begin
                  new_req(d, p);
               end
            end
         end
      end
   endtask

   initial begin
      logic [DW-1:0] rd, r0, r1;
      int t0, t1, both, nbad, n;
      int ord[10];
      logic g1;

      tbl[0] = '{0, 1'b1, 7'h00, 32'h11111111, 32'h00000000};
      tbl[1] = '{1, 1'b1, 7'h7F, 32'hA5A5A5A5, 32'h00000000};
      tbl[2] = '{0, 1'b0, 7'h7F, 32'h0,        32'hA5A5A5A5};
      tbl[3] = '{1, 1'b0, 7'h00, 32'h0,        32'h11111111};
      tbl[4] = '{1, 1'b1, 7'h00, 32'hCAFEF00D, 32'h11111111};
      tbl[5] = '{0, 1'b0, 7'h00, 32'h0,        32'hCAFEF00D};
      tbl[6] = '{0, 1'b0, 7'h05, 32'h0,        32'h00000000};
      tbl[7] = '{1, 1'b0, 7'h7F, 32'h0,        32'hA5A5A5A5};
      tbl[8] = '{0, 1'b1, 7'h40, 32'hFFFFFFFF, 32'h00000000};
      tbl[9] = '{1, 1'b0, 7'h40, 32'h0,        32'hFFFFFFFF};

      clr_inputs();
      rst = 1'b1;
      mem_init = 1'b0;
      pulse_mem_init();
      do_reset();
      check_reset(0, "rst");
      check_reset(1, "rst");

      // idle bus
      nbad = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         for (int d = 0; d < 2; d++)
            if (mem_cs[d] || mem_drive[d] || ack0[d] || ack1[d] || busy[d]) nbad++;
      end
      check("idle20", nbad, 0);

      // table vectors on both instances
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 10; i++) begin
            txn(d, tbl[i].p, tbl[i].w, tbl[i].a, tbl[i].wd, rd);
            check($sformatf("tbl%0d_d%0d", i, d), rd, tbl[i].er);
         end

      // write then read on port 0
      txn(0, 0, 1'b1, 7'h10, 32'hDEADBEEF, rd);
      txn(0, 0, 1'b0, 7'h10, 32'h0, rd);
      check("wr_rd_10", rd, 32'hDEADBEEF);

      // round-robin tie straight after reset
      do_reset();
      drive(1, 0, 1'b1, 1'b0, 7'h7F, 32'h0);
      drive(1, 1, 1'b1, 1'b0, 7'h00, 32'h0);
      t0 = -1; t1 = -1; both = 0; r0 = '0; r1 = '0; g1 = 1'bx;
      for (int k = 1; k <= 12 && (t0 < 0 || t1 < 0); k++) begin
         tick();
         if (k == 1) g1 = grant[1];
         if (ack0[1] && ack1[1]) both++;
         if (ack0[1] && t0 < 0) begin t0 = k; r0 = rdata0[1]; req0[1] = 1'b0; end
         if (ack1[1] && t1 < 0) begin t1 = k; r1 = rdata1[1]; req1[1] = 1'b0; end
      end
      tick();
      check("rr_first_grant", g1, 0);
      check("rr_ack_times", {t0, t1}, {32'd2, 32'd5});
      check("rr_no_overlap", both, 0);
      check("rr_rdata", {r0, r1}, {32'hA5A5A5A5, 32'hCAFEF00D});

      // fixed priority with anti-starvation, both requests held
      drive(0, 0, 1'b1, 1'b0, 7'h01, 32'h0);
      drive(0, 1, 1'b1, 1'b0, 7'h02, 32'h0);
      n = 0;
      for (int k = 0; k < 60 && n < 10; k++) begin
         tick();
         if (ack0[0] || ack1[0]) begin
            ord[n] = int'(ack1[0]);
            n++;
         end
      end
      req0[0] = 1'b0;
      req1[0] = 1'b0;
      tick();
      tick();
      check("starve_count", n, 10);
      for (int i = 0; i < 10; i++)
         if (i < n) check($sformatf("starve_ord%0d", i), ord[i], (i % 5 == 4) ? 1 : 0);

      // inputs changed during ACCESS must not reach memory
      drive(0, 0, 1'b1, 1'b1, 7'h22, 32'h12345678);
      tick();
      check("chg_access", {mem_cs[0], mem_drive[0], mem_addr[0], mem_wdata[0]},
            {1'b1, 1'b1, 7'h22, 32'h12345678});
      drive(0, 0, 1'b1, 1'b1, 7'h23, 32'h0BADBEEF);
      tick();
      check("chg_ack", ack0[0], 1);
      req0[0] = 1'b0;
      tick();
      txn(0, 0, 1'b0, 7'h22, 32'h0, rd);
      check("chg_rd22", rd, 32'h12345678);
      txn(0, 0, 1'b0, 7'h23, 32'h0, rd);
      check("chg_rd23", rd, 32'h0);

      // reset during RESP of a port 1 read
      drive(1, 1, 1'b1, 1'b0, 7'h40, 32'h0);
      tick();
      tick();
      check("rstresp_ack_before", ack1[1], 1);
      req1[1] = 1'b0;
      rst = 1'b1;
      tick();
      check("rstresp_ack_after", ack1[1], 0);
      check_reset(1, "rstresp");
      check_reset(0, "rstresp");
      rst = 1'b0;
      txn(1, 0, 1'b0, 7'h40, 32'h0, rd);
      check("rstresp_after_rd", rd, 32'hFFFFFFFF);

      // randomized traffic against the timeline model
      clr_inputs();
      pulse_mem_init();
      do_reset();
      run_random(600);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
